// File: rtl/ysyx_22040750_axi_rd_responder.sv
// AXI4 read-channel slave: turns each AR burst into one-per-beat reads of a
// one-cycle-latency 64-bit memory port and returns R beats under backpressure.
module ysyx_22040750_axi_rd_responder #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  I_clk,
    input  logic                  I_rst,
    input  logic [ADDR_WIDTH-1:0] I_araddr,
    input  logic                  I_arvalid,
    output logic                  O_arready,
    input  logic [7:0]            I_arlen,
    input  logic [2:0]            I_arsize,
    input  logic [1:0]            I_arburst,
    output logic [DATA_WIDTH-1:0] O_rdata,
    output logic [1:0]            O_rresp,
    output logic                  O_rlast,
    output logic                  O_rvalid,
    input  logic                  I_rready,
    output logic [ADDR_WIDTH-1:0] O_mem_raddr,
    output logic                  O_mem_ren,
    input  logic [DATA_WIDTH-1:0] I_mem_rdata,
    output logic [2:0]            O_dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_MEM_RD   = 3'd1,
        S_MEM_WAIT = 3'd2,
        S_RESP     = 3'd3,
        S_ERR_RESP = 3'd4
    } state_t;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    state_t                r_state;
    state_t                w_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [7:0]            r_len;
    logic [2:0]            r_size;
    logic [1:0]            r_burst;
    logic [7:0]            r_beat_cnt;
    logic [DATA_WIDTH-1:0] r_data;

    logic                  w_ar_hs;
    logic                  w_ar_illegal;
    logic                  w_last;
    logic [ADDR_WIDTH-1:0] w_step;
    logic [5:0]            w_shift_amt;
    logic [DATA_WIDTH-1:0] w_mask;
    logic [DATA_WIDTH-1:0] w_beat_data;

    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both high; once O_rvalid rises, O_rdata/O_rresp/O_rlast hold until
    // the beat is taken, and O_arready is only offered from IDLE.
    assign w_ar_hs      = I_arvalid && O_arready;
    assign w_ar_illegal = (I_arburst != BURST_FIXED && I_arburst != BURST_INCR) ||
                          (I_arsize > 3'd3);
    assign w_last       = (r_beat_cnt == r_len);
    assign w_shift_amt  = {r_addr[2:0], 3'b000};
    assign O_dbg_state  = r_state;

    always_comb begin
        w_step = '0;
        case (r_size)
            3'd0:    w_step = ADDR_WIDTH'(1);
            3'd1:    w_step = ADDR_WIDTH'(2);
            3'd2:    w_step = ADDR_WIDTH'(4);
            default: w_step = ADDR_WIDTH'(8);
        endcase
        if (r_burst != BURST_INCR) begin
            w_step = '0;
        end
    end

    // Narrow beats are right-justified: shift the addressed byte lane down,
    // then clear everything above the beat width.
    always_comb begin
        w_mask = '1;
        case (r_size)
            3'd0:    w_mask = DATA_WIDTH'(64'h0000_0000_0000_00ff);
            3'd1:    w_mask = DATA_WIDTH'(64'h0000_0000_0000_ffff);
            3'd2:    w_mask = DATA_WIDTH'(64'h0000_0000_ffff_ffff);
            default: w_mask = '1;
        endcase
        w_beat_data = (I_mem_rdata >> w_shift_amt) & w_mask;
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_len      <= '0;
            r_size     <= '0;
            r_burst    <= '0;
            r_beat_cnt <= '0;
            r_data     <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (w_ar_hs) begin
                        r_addr     <= I_araddr;
                        r_len      <= I_arlen;
                        r_size     <= I_arsize;
                        r_burst    <= I_arburst;
                        r_beat_cnt <= '0;
                    end
                end
                S_MEM_WAIT: begin
                    r_data <= w_beat_data;
                end
                S_RESP: begin
                    if (I_rready && !w_last) begin
                        r_beat_cnt <= r_beat_cnt + 8'd1;
                        r_addr     <= r_addr + w_step;
                    end
                end
                S_ERR_RESP: begin
                    if (I_rready && !w_last) begin
                        r_beat_cnt <= r_beat_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs are forced quiet while reset is held so an abandoned burst
    // produces neither beats nor memory strobes in the reset cycle.
    always_comb begin
        w_next      = r_state;
        O_arready   = 1'b0;
        O_rvalid    = 1'b0;
        O_rdata     = '0;
        O_rresp     = RESP_OKAY;
        O_rlast     = 1'b0;
        O_mem_ren   = 1'b0;
        O_mem_raddr = '0;
        case (r_state)
            S_IDLE: begin
                O_arready = !I_rst;
                if (I_arvalid && !I_rst) begin
                    w_next = w_ar_illegal ? S_ERR_RESP : S_MEM_RD;
                end
            end
            S_MEM_RD: begin
                O_mem_ren   = !I_rst;
                O_mem_raddr = I_rst ? '0 : {r_addr[ADDR_WIDTH-1:3], 3'b000};
                w_next      = S_MEM_WAIT;
            end
            S_MEM_WAIT: begin
                w_next = S_RESP;
            end
            S_RESP: begin
                O_rvalid = !I_rst;
                O_rdata  = I_rst ? '0 : r_data;
                O_rlast  = w_last && !I_rst;
                if (I_rready) begin
                    w_next = w_last ? S_IDLE : S_MEM_RD;
                end
            end
            S_ERR_RESP: begin
                O_rvalid = !I_rst;
                O_rresp  = I_rst ? RESP_OKAY : RESP_SLVERR;
                O_rlast  = w_last && !I_rst;
                if (I_rready && w_last) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: doc/ysyx_22040750_axi_rd_responder.md
# ysyx_22040750_axi_rd_responder

AXI4 read-channel slave that serves the bursts issued by the fetch and cache controllers (4-beat 64-bit INCR cacheline refills, single-beat 32-bit FIXED MMIO reads). It sits between the core's AXI read master and a synchronous 64-bit memory read port with one-cycle latency. It converts each AR request into a sequence of memory reads and R beats, honouring R-channel backpressure. Illegal requests complete with SLVERR beats.

## Interface
Parameters:
- ADDR_WIDTH, 32, AXI and memory address width
- DATA_WIDTH, 64, R data and memory data width; fixed at 64 (max arsize 3'b011)

Ports:
- Reset I_rst, synchronous, active-high; clock I_clk.
- I_clk  input  1  clock
- I_rst  input  1  synchronous active-high reset
- I_araddr  input  32  burst start byte address
- I_arvalid  input  1  AR request valid
- O_arready  output  1  AR accept; high only in IDLE
- I_arlen  input  8  beats minus one
- I_arsize  input  3  log2 bytes per beat
- I_arburst  input  2  00 FIXED, 01 INCR, others illegal
- O_rdata  output  64  beat data, right-justified for narrow sizes
- O_rresp  output  2  00 OKAY, 10 SLVERR
- O_rlast  output  1  final beat of burst
- O_rvalid  output  1  R beat valid
- I_rready  input  1  R beat accept
- O_mem_raddr  output  32  8-byte-aligned memory read address
- O_mem_ren  output  1  memory read strobe, one cycle per beat
- I_mem_rdata  input  64  memory data, valid the cycle after O_mem_ren

## Operation
- States: IDLE, MEM_RD, MEM_WAIT, RESP, ERR_RESP.
- IDLE: O_arready=1. On I_arvalid&&O_arready, latch addr, len, size, burst; beat_cnt<=0. Go ERR_RESP if arburst in {10,11} or arsize>3, else MEM_RD.
- MEM_RD: O_mem_ren=1, O_mem_raddr={addr[31:3],3'b000}; go MEM_WAIT.
- MEM_WAIT: at clock edge, data_reg <= (I_mem_rdata >> {addr[2:0],3'b000}) with bits at and above 8<<size cleared (size 3: no clearing); go RESP.
- RESP: O_rvalid=1, O_rdata=data_reg, O_rresp=00, O_rlast=(beat_cnt==len). On I_rready: if last go IDLE; else beat_cnt+1, addr += (burst==INCR ? 1<<size : 0), go MEM_RD. Without I_rready, hold all R outputs stable.
- ERR_RESP: O_rvalid=1, O_rdata=0, O_rresp=10, O_rlast=(beat_cnt==len); no memory reads; each handshake increments beat_cnt; last handshake goes IDLE.
- Address arithmetic is 32-bit wrapping. There is no 4KB-boundary check.
- Only one outstanding burst. AR requests are never accepted while a burst is active.

## Timing
- Reset: state IDLE. O_rvalid, O_rlast, O_mem_ren, O_rdata, O_rresp, O_mem_raddr are all 0. O_arready=0 while I_rst is high and 1 in the first cycle after reset is released.
- Reset mid-burst: the burst is abandoned and no further beats or mem reads occur. O_rvalid is 0 from the cycle after the reset edge.
- AR handshake at cycle T: O_mem_ren at T+1, data captured at the end of T+2, first O_rvalid at T+3.
- With I_rready=1, one beat every 3 cycles. A 4-beat burst's final handshake is at T+12.
- After the final R handshake at cycle N, O_arready=1 at N+1. The earliest next AR handshake is N+1.
- ERR_RESP: first O_rvalid at T+1; one beat per cycle with I_rready=1.
- O_rlast is never asserted without O_rvalid. O_mem_ren is never asserted outside MEM_RD.

## Test plan
- INCR burst, araddr 0x80000020, arlen 3, arsize 3, I_rready=1: mem reads at 0x80000020/28/30/38. Four OKAY beats return the memory words in order. O_rlast is asserted only on beat 4. First O_rvalid is 3 cycles after the AR handshake.
- FIXED narrow read, araddr 0xa0000004, arlen 0, arsize 2, memory word 0x11223344_55667788: mem read at 0xa0000000. Result is O_rdata=0x00000000_11223344, O_rlast=1, O_rresp=00.
- Backpressure: during the INCR burst above, hold I_rready=0 for 5 cycles on beat 2. O_rdata and O_rlast stay stable, no extra O_mem_ren is issued, and beats 2–4 resume in order.
- Illegal burst, arburst 2'b10, arlen 1: O_mem_ren never fires. Two beats return with O_rresp=10 and O_rdata=0; O_rlast is set on the second.
- Reset mid-burst: assert I_rst for 1 cycle after beat 1 of a 4-beat burst. O_rvalid=0 the next cycle and O_arready=1 after release. A new FIXED read at 0x80000000 then completes correctly.
- Back-to-back: keep I_arvalid high through the final beat of a burst. O_arready rises in the cycle after the last R handshake, and the second burst's addresses are used with no beat overlap.
